// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state encoding
// and the requester count.
package memory_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int NUM_REQUESTERS = 2;

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Combinational round-robin choice between two requesters. A lone requester
// always wins; on contention the one that did not win last time is chosen.
module rr_picker
    import memory_arbiter_pkg::*;
(
    input  logic                      req0,
    input  logic                      req1,
    input  logic                      last,
    output logic [NUM_REQUESTERS-1:0] gnt
);

    // One-hot winner selection from the request pair and the Last pointer.
    always_comb begin
        gnt = 2'b00;
        case ({req1, req0})
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory with
// combinational read data; one access per two cycles.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int BITS              = 64,
    parameter int ADDRESS_BUS_WIDTH = 6
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Req0,
    input  logic                         Req1,
    input  logic                         ReqWE0,
    input  logic                         ReqWE1,
    input  logic [ADDRESS_BUS_WIDTH-1:0] ReqAddr0,
    input  logic [ADDRESS_BUS_WIDTH-1:0] ReqAddr1,
    input  logic [BITS-1:0]              ReqD0,
    input  logic [BITS-1:0]              ReqD1,
    output logic                         Gnt0,
    output logic                         Gnt1,
    output logic                         RespValid0,
    output logic                         RespValid1,
    output logic [BITS-1:0]              RespQ0,
    output logic [BITS-1:0]              RespQ1,
    output logic [BITS-1:0]              MemD,
    output logic [ADDRESS_BUS_WIDTH-1:0] MemAddress,
    output logic                         MemWE,
    input  logic [BITS-1:0]              MemQ
);

    state_e                         state_q, state_d;
    logic                           last_q, last_d;
    logic                           owner_q, owner_d;
    logic                           mem_we_q, mem_we_d;
    logic [ADDRESS_BUS_WIDTH-1:0]   addr_q, addr_d;
    logic [BITS-1:0]                data_q, data_d;
    logic [NUM_REQUESTERS-1:0]      resp_valid_q, resp_valid_d;
    logic [BITS-1:0]                resp_q0_q, resp_q0_d;
    logic [BITS-1:0]                resp_q1_q, resp_q1_d;
    logic [NUM_REQUESTERS-1:0]      pick_s;
    logic [NUM_REQUESTERS-1:0]      gnt_s;

    rr_picker u_rr_picker (
        .req0 (Req0),
        .req1 (Req1),
        .last (last_q),
        .gnt  (pick_s)
    );

    // Grants only exist in IDLE; RST masks them so nothing is accepted in reset.
    always_comb begin
        if ((state_q == IDLE) && !RST) begin
            gnt_s = pick_s;
        end else begin
            gnt_s = 2'b00;
        end
    end

    // Next-state logic: latch the winner's request on grant, complete it in ACCESS.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        data_d       = data_q;
        mem_we_d     = 1'b0;
        resp_valid_d = 2'b00;
        resp_q0_d    = resp_q0_q;
        resp_q1_d    = resp_q1_q;
        case (state_q)
            IDLE: begin
                if (gnt_s != 2'b00) begin
                    state_d  = ACCESS;
                    owner_d  = gnt_s[1];
                    last_d   = gnt_s[1];
                    mem_we_d = gnt_s[1] ? ReqWE1   : ReqWE0;
                    addr_d   = gnt_s[1] ? ReqAddr1 : ReqAddr0;
                    data_d   = gnt_s[1] ? ReqD1    : ReqD0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d      = IDLE;
                resp_valid_d = owner_q ? 2'b10 : 2'b01;
                // mem_we_q still reflects the latched direction during ACCESS.
                if (!mem_we_q && owner_q) begin
                    resp_q1_d = MemQ;
                end else if (!mem_we_q) begin
                    resp_q0_d = MemQ;
                end else begin
                    resp_q0_d = resp_q0_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset favours requester 0 on first contention.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            resp_valid_q <= 2'b00;
            resp_q0_q    <= '0;
            resp_q1_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            mem_we_q     <= mem_we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            resp_valid_q <= resp_valid_d;
            resp_q0_q    <= resp_q0_d;
            resp_q1_q    <= resp_q1_d;
        end
    end

    assign Gnt0       = gnt_s[0];
    assign Gnt1       = gnt_s[1];
    assign RespValid0 = resp_valid_q[0];
    assign RespValid1 = resp_valid_q[1];
    assign RespQ0     = resp_q0_q;
    assign RespQ1     = resp_q1_q;
    assign MemD       = data_q;
    assign MemAddress = addr_q;
    assign MemWE      = mem_we_q;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter BITS, default 64, data word width of the shared memory.
REQ-002 Parameter ADDRESS_BUS_WIDTH, default 6, memory address width; depth is 2^ADDRESS_BUS_WIDTH words.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 Req0, Req1  input  1 each  access request from requester 0/1; held until granted.
REQ-006 ReqWE0, ReqWE1  input  1 each  1 = write, 0 = read; valid with Req.
REQ-007 ReqAddr0, ReqAddr1  input  ADDRESS_BUS_WIDTH each  target address; valid with Req.
REQ-008 ReqD0, ReqD1  input  BITS each  write data; valid with Req.
REQ-009 Gnt0, Gnt1  output  1 each  acceptance strobe; request fields sampled on the edge ending this cycle.
REQ-010 RespValid0, RespValid1  output  1 each  one-cycle completion pulse.
REQ-011 RespQ0, RespQ1  output  BITS each  read data; holds until the next read completion for that requester.
REQ-012 MemD  output  BITS  write data to memory.
REQ-013 MemAddress  output  ADDRESS_BUS_WIDTH  memory address.
REQ-014 MemWE  output  1  memory write enable, driven directly from a flop (glitch-free).
REQ-015 MemQ  input  BITS  combinational read data from memory at MemAddress.

Function
REQ-016 FSM states are IDLE and ACCESS; reset state is IDLE.
REQ-017 In IDLE with any Req high, exactly one Gnt is asserted combinationally; next state is ACCESS. With no Req, the FSM stays in IDLE and both Gnt are 0.
REQ-018 Gnt is 0 in ACCESS and whenever RST is high.
REQ-019 Arbitration is round-robin via a 1-bit Last pointer: single requester always wins; when both request, the winner is the requester other than Last; Last updates to the winner only on a grant.
REQ-020 On grant, owner id, WE, address and data are latched; MemAddress/MemD take the latched values on the same edge.
REQ-021 MemWE is 1 during the ACCESS cycle only when the latched request is a write; otherwise 0.
REQ-022 MemAddress and MemD hold their values through ACCESS and the following IDLE cycle(s) until the next grant.
REQ-023 A read captures MemQ into the owner's RespQ on the edge ending ACCESS; a write leaves RespQ unchanged.
REQ-024 RespValid of the owner pulses for the single cycle after ACCESS (reads and writes); the other RespValid stays 0.
REQ-025 ACCESS always returns to IDLE after one cycle; sustained throughput is one access per 2 cycles; read latency is grant cycle + 2.
REQ-026 A new grant is allowed in the same IDLE cycle in which RespValid pulses.
REQ-027 Changes on Req/ReqWE/ReqAddr/ReqD outside the grant cycle have no effect.

Reset
REQ-028 While RST is high: FSM = IDLE; Last = 1 (requester 0 favoured); MemWE, MemAddress, MemD, RespValid0/1, RespQ0/1 = 0.
REQ-029 RST asserted during ACCESS aborts the access: MemWE drops to 0 immediately (asynchronous), no RespValid is issued, and the aborted request is not retried.

Structure
REQ-030 A shared package holds the state enumeration (IDLE, ACCESS) and the constant NUM_REQUESTERS = 2.
REQ-031 Round-robin selection is a single sub-module, rr_picker (inputs: two requests, Last; outputs: one-hot grant), purely combinational.

Verification
REQ-032 Req0 write addr 5 data 0xA5, then Req0 read addr 5 -> MemWE high for exactly one cycle; RespQ0 = 0xA5 with RespValid0 at grant + 2.
REQ-033 Req0 and Req1 held high continuously from reset -> grants alternate 0,1,0,1, one grant every 2 cycles.
REQ-034 Req1 alone, repeated 3 times -> Gnt1 each time, Gnt0 never asserted, Last = 1.
REQ-035 RST pulsed during an ACCESS write to addr 7 -> MemWE falls asynchronously, no RespValid, all outputs 0.
REQ-036 ReqAddr0 changed from 3 to 9 one cycle after Gnt0 -> MemAddress stays 3 through the access.
